bounded_updown_counter: RTL and testbench
=========================================

Name: bounded_updown_counter

Overview:
- Parametrised, general-purpose up/down counter for control and sequencing logic. It is the successor to the fixed 4-bit up, down, up/down, load and clock-enable counter variants.
- Adds runtime-programmable lower and upper bounds, wrap or saturate mode, a synchronous clear, a terminal-count pulse and a sticky saturation flag.
- Optional input prescaler divides the count rate.

Parameters:
- WIDTH, 4, counter and bound width in bits (min 2).
- RESET_VAL, 0, count value applied on async reset (WIDTH bits).
- PRESCALE_DIV, 4, enable divide ratio (min 2); used only when CNT_PRESCALE_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear to 0; also clears sat_hit.
- load  in  1  synchronous load of d.
- d  in  WIDTH  load value.
- en  in  1  count enable (one step per qualified cycle).
- up_dn  in  1  1 = count up, 0 = count down.
- mode  in  1  0 = wrap, 1 = saturate.
- lo  in  WIDTH  lower bound, unsigned.
- hi  in  WIDTH  upper bound, unsigned.
- count  out  WIDTH  registered count.
- tc  out  1  registered one-cycle terminal-count pulse.
- sat_hit  out  1  sticky flag: a saturate-mode boundary step occurred.
- cfg_err  out  1  combinational, high when lo > hi.

Behaviour:
- Async reset (rst_n = 0): count = RESET_VAL, tc = 0, sat_hit = 0, prescaler = 0. Takes effect immediately, mid-operation included. Release is synchronous to clk.
- Per-cycle priority: clr > load > step > hold.
- clr: count <= 0, sat_hit <= 0, tc <= 0.
- load: count <= d as-is, with no clamping to [lo, hi]. tc <= 0.
- step: occurs when en (or the prescaler tick, see Optional Feature) is high and neither clr nor load is high. All compares are unsigned.
  - Up: if count >= hi, next = lo (wrap) or hi (sat); else next = count + 1.
  - Down: if count <= lo, next = hi (wrap) or lo (sat); else next = count - 1.
- Boundary step: a step taken while count >= hi (up) or count <= lo (down).
  - tc = 1 for exactly the cycle after any boundary step, in both modes. tc = 0 otherwise.
  - In sat mode, a boundary step also sets sat_hit = 1. It stays set until clr or reset.
- Out-of-range count (after a load or a bound change) is handled by the same compare rules. Example: count 13 with hi 9, stepping up in wrap mode, goes to lo. No intermediate values.
- lo = hi: every step is a boundary step. count goes to lo = hi and tc pulses every step.
- lo > hi: cfg_err = 1. The counter still follows the rules above (deterministic, no X). Behaviour under this condition is not a supported use.
- Full-range case (lo = 0, hi = 2^WIDTH - 1): wrap mode reproduces plain modulo-2^WIDTH counting.
- Latency: one cycle from a qualified control input to count and tc.
- No arithmetic overflow is possible: count + 1 is only used when count < hi, and count - 1 only when count > lo.
- mode, up_dn, lo and hi may change on any cycle and take effect on the next step.

Optional Feature:
- Macro CNT_PRESCALE_EN.
- Defined:
  - A prescaler counter of width clog2(PRESCALE_DIV) advances only while en = 1.
  - A step occurs only on the cycle the prescaler reaches PRESCALE_DIV - 1; the prescaler then returns to 0.
  - The prescaler holds while en = 0, and is cleared by clr, load and reset.
- Undefined: no prescaler logic is built, and every en cycle is a step.

Decomposition:
- Package cnt_pkg:
  - Mode typedef (1-bit enum): CNT_MODE_WRAP = 0, CNT_MODE_SAT = 1.
  - Direction constants: CNT_DIR_UP = 1, CNT_DIR_DN = 0.
- Sub-module cnt_prescaler (clk, rst_n, clr, en, tick): instantiated only under CNT_PRESCALE_EN.
- Next-state compare logic stays in the top module.

Test Plan:
- Reset: count at 7 (WIDTH 4), drive rst_n low between clock edges -> count = 0, tc = 0 and sat_hit = 0 with no clock edge. After release with en = 1, up, lo 0, hi 15: count = 1 after the first edge.
- Wrap up: lo 4, hi 9, load 4, then en = 1 for 6 cycles -> count 5, 6, 7, 8, 9, 4. tc high for exactly the one cycle after the 9->4 step. sat_hit stays 0.
- Saturate down: lo 2, hi 12, mode 1, load 3, en = 1, down -> count 2, 2, 2. tc pulses after each step taken at 2, sat_hit = 1. Then clr -> count = 0, sat_hit = 0.
- Priority: clr = load = en = 1 with d = 11 -> count = 0. Then load = en = 1 with d = 11 -> count = 11, tc = 0.
- Out-of-range and cfg_err:
  - lo 4, hi 9, load 13, up, wrap -> next count = 4 with a tc pulse.
  - Set lo 10, hi 5 -> cfg_err = 1 in the same cycle.
- CNT_PRESCALE_EN with PRESCALE_DIV = 3: en held high from count 0 -> count increments on every 3rd cycle (0, 0, 1, 1, 1, 2, ...). Dropping en for 2 cycles mid-phase delays the next increment by exactly 2 cycles.

Source files
------------

// File: rtl/bounded_updown_counter_pkg.sv
// Shared types and constants for bounded_updown_counter (package cnt_pkg).
//   cnt_mode_e : wrap / saturate boundary behaviour
//   CNT_DIR_*  : direction encoding of up_dn
package cnt_pkg;

    typedef enum logic {
        CNT_MODE_WRAP = 1'b0,
        CNT_MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic CNT_DIR_UP = 1'b1;
    localparam logic CNT_DIR_DN = 1'b0;

endpackage

// File: rtl/bounded_updown_counter_if.sv
// Control/status bundle of bounded_updown_counter.
//   master : drives clr, load, d, en, up_dn, mode, lo, hi; observes status
//   slave  : the counter; drives count, tc, sat_hit, cfg_err
interface bounded_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             up_dn;
    logic             mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             sat_hit;
    logic             cfg_err;

    modport master (
        output clr, load, d, en, up_dn, mode, lo, hi,
        input  count, tc, sat_hit, cfg_err
    );

    modport slave (
        input  clr, load, d, en, up_dn, mode, lo, hi,
        output count, tc, sat_hit, cfg_err
    );
endinterface

// File: rtl/bounded_updown_counter_prescaler.sv
// cnt_prescaler: enable-rate divider, built only when CNT_PRESCALE_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous return to phase 0
//   en         : advance the phase counter
//   tick       : combinational, high on the en cycle at phase DIV-1
`ifdef CNT_PRESCALE_EN
module cnt_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Phase advance; wraps to 0 on the tick cycle
    always_comb begin
        tick    = 1'b0;
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            if (phase_q == PW'(DIV - 1)) begin
                tick    = 1'b1;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= '0;
        else        phase_q <= phase_d;
    end
endmodule
`endif

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with programmable [lo, hi], wrap or saturate mode,
// synchronous clear/load, terminal-count pulse and sticky saturation flag.
// Optional enable prescaler when CNT_PRESCALE_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of bounded_updown_counter_if
//                (clr, load, d, en, up_dn, mode, lo, hi -> count, tc, sat_hit, cfg_err)
module bounded_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef CNT_PRESCALE_EN
    ,
    parameter int unsigned     PRESCALE_DIV = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bounded_updown_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             sat_q;
    logic             sat_d;
    logic             step_c;
    logic             boundary_c;
    logic             is_sat_c;

`ifdef CNT_PRESCALE_EN
    logic pre_clr_c;
    assign pre_clr_c = bus.clr | bus.load;

    cnt_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr_c),
        .en    (bus.en),
        .tick  (step_c)
    );
`else
    assign step_c = bus.en;
`endif

    assign is_sat_c = (cnt_mode_e'(bus.mode) == CNT_MODE_SAT);

    // Next state: clr > load > step > hold; out-of-range counts fall into the boundary branch
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        sat_d      = sat_q;
        boundary_c = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (bus.load) begin
            count_d = bus.d;
        end else if (step_c) begin
            if (bus.up_dn == CNT_DIR_UP) begin
                if (count_q >= bus.hi) begin
                    boundary_c = 1'b1;
                    count_d    = is_sat_c ? bus.hi : bus.lo;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q <= bus.lo) begin
                    boundary_c = 1'b1;
                    count_d    = is_sat_c ? bus.lo : bus.hi;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            if (boundary_c) begin
                tc_d = 1'b1;
                if (is_sat_c) sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.sat_hit = sat_q;
    assign bus.cfg_err = (bus.lo > bus.hi);

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Self-checking bench for bounded_updown_counter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the counter.
// Build with CNT_PRESCALE_EN defined to exercise the prescaler (divide by 3).
module tb_bounded_updown_counter;
    localparam int unsigned W      = 4;
    localparam int          TB_DIV = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // reference model state
    int m_count;
    int m_tc;
    int m_sat;
    int m_pre;

    bounded_updown_counter_if #(.WIDTH(W)) bus ();

`ifdef CNT_PRESCALE_EN
    bounded_updown_counter #(.WIDTH(W), .RESET_VAL(4'd0), .PRESCALE_DIV(TB_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`else
    bounded_updown_counter #(.WIDTH(W), .RESET_VAL(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int lo_i;
        int hi_i;
        lo_i = int'(bus.lo);
        hi_i = int'(bus.hi);
        chk({tag, ".count"},   32'(bus.count),   32'(m_count));
        chk({tag, ".tc"},      32'(bus.tc),      32'(m_tc));
        chk({tag, ".sat_hit"}, 32'(bus.sat_hit), 32'(m_sat));
        chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'(lo_i > hi_i));
    endtask

    // Behavioural reference: applies one clock edge using the rules on plain integers
    task automatic model_edge();
        int  c;
        int  lo_i;
        int  hi_i;
        bit  do_step;
        if (!rst_n) begin
            m_count = 0; m_tc = 0; m_sat = 0; m_pre = 0;
            return;
        end
        c    = m_count;
        lo_i = int'(bus.lo);
        hi_i = int'(bus.hi);
        m_tc = 0;
        if (bus.clr) begin
            m_count = 0; m_sat = 0; m_pre = 0;
        end else if (bus.load) begin
            m_count = int'(bus.d); m_pre = 0;
        end else begin
            do_step = bus.en;
`ifdef CNT_PRESCALE_EN
            if (bus.en) begin
                if (m_pre == TB_DIV - 1) begin
                    m_pre = 0;
                end else begin
                    m_pre   = m_pre + 1;
                    do_step = 1'b0;
                end
            end
`endif
            if (do_step) begin
                if (bus.up_dn) begin
                    if (c >= hi_i) begin
                        m_tc    = 1;
                        m_count = bus.mode ? hi_i : lo_i;
                        if (bus.mode) m_sat = 1;
                    end else begin
                        m_count = c + 1;
                    end
                end else begin
                    if (c <= lo_i) begin
                        m_tc    = 1;
                        m_count = bus.mode ? lo_i : hi_i;
                        if (bus.mode) m_sat = 1;
                    end else begin
                        m_count = c - 1;
                    end
                end
            end
        end
    endtask

    // One clock: model follows the edge, DUT sampled on the falling edge
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_model(tag);
    endtask

    task automatic drive(input bit clr, input bit load, input int d, input bit en,
                         input bit up, input bit mode, input int lo, input int hi);
        bus.clr   = clr;
        bus.load  = load;
        bus.d     = W'(d);
        bus.en    = en;
        bus.up_dn = up;
        bus.mode  = mode;
        bus.lo    = W'(lo);
        bus.hi    = W'(hi);
    endtask

    initial begin
        int exp_cnt[6];
        int exp_tc[6];
        checks = 0;
        errors = 0;
        m_count = 0; m_tc = 0; m_sat = 0; m_pre = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0, 15);
        repeat (2) @(negedge clk);
        chk_model("reset_init");
        rst_n = 1'b1;

        // async reset mid-cycle from count 7
        drive(0, 1, 7, 0, 1, 0, 0, 15);
        cyc("load7");
        chk("load7.explicit", 32'(bus.count), 32'd7);
        drive(0, 0, 0, 1, 1, 0, 0, 15);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.count", 32'(bus.count), 32'd0);
        chk("async_rst.tc",    32'(bus.tc),    32'd0);
        chk("async_rst.sat",   32'(bus.sat_hit), 32'd0);
        cyc("rst_hold");
        rst_n = 1'b1;
        cyc("rst_release");
`ifndef CNT_PRESCALE_EN
        chk("rst_release.first_step", 32'(bus.count), 32'd1);
`endif

        // wrap up across [4,9]
        drive(0, 1, 4, 0, 1, 0, 4, 9);
        cyc("wrap_load");
        drive(0, 0, 0, 1, 1, 0, 4, 9);
        exp_cnt = '{5, 6, 7, 8, 9, 4};
        exp_tc  = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            cyc("wrap_up");
`ifndef CNT_PRESCALE_EN
            chk("wrap_up.count", 32'(bus.count), 32'(exp_cnt[i]));
            chk("wrap_up.tc",    32'(bus.tc),    32'(exp_tc[i]));
`endif
        end
        cyc("wrap_after");

        // saturate down at lo = 2
        drive(0, 1, 3, 0, 0, 1, 2, 12);
        cyc("sat_load");
        drive(0, 0, 0, 1, 0, 1, 2, 12);
        exp_tc = '{0, 1, 1, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            cyc("sat_dn");
`ifndef CNT_PRESCALE_EN
            chk("sat_dn.count", 32'(bus.count),   32'd2);
            chk("sat_dn.tc",    32'(bus.tc),      32'(exp_tc[i]));
            chk("sat_dn.sat",   32'(bus.sat_hit), 32'(i > 0));
`endif
        end
        drive(1, 0, 0, 0, 0, 1, 2, 12);
        cyc("sat_clr");
        chk("sat_clr.sat", 32'(bus.sat_hit), 32'd0);

        // priority
        drive(1, 1, 11, 1, 1, 0, 0, 15);
        cyc("prio_clr");
        chk("prio_clr.count", 32'(bus.count), 32'd0);
        drive(0, 1, 11, 1, 1, 0, 0, 15);
        cyc("prio_load");
        chk("prio_load.count", 32'(bus.count), 32'd11);
        chk("prio_load.tc",    32'(bus.tc),    32'd0);

        // out-of-range count wraps straight to lo
        drive(0, 1, 13, 0, 1, 0, 4, 9);
        cyc("oor_load");
        drive(0, 0, 0, 1, 1, 0, 4, 9);
        cyc("oor_step");
`ifdef CNT_PRESCALE_EN
        repeat (TB_DIV - 1) cyc("oor_step");
`endif
        chk("oor_step.count", 32'(bus.count), 32'd4);
        chk("oor_step.tc",    32'(bus.tc),    32'd1);

        // cfg_err is combinational
        bus.en = 1'b0;
        bus.lo = W'(10);
        bus.hi = W'(5);
        #1;
        chk("cfg_err", 32'(bus.cfg_err), 32'd1);
        cyc("cfg_err_hold");

`ifdef CNT_PRESCALE_EN
        // divide-by-3 cadence, then a 2-cycle en gap mid-phase
        drive(1, 0, 0, 0, 1, 0, 0, 15);
        cyc("pre_clr");
        drive(0, 0, 0, 1, 1, 0, 0, 15);
        exp_cnt = '{0, 0, 1, 1, 1, 2};
        for (int i = 0; i < 6; i++) begin
            cyc("pre_run");
            chk("pre_run.count", 32'(bus.count), 32'(exp_cnt[i]));
        end
        cyc("pre_phase1");
        bus.en = 1'b0;
        repeat (2) cyc("pre_gap");
        bus.en = 1'b1;
        cyc("pre_resume");
        chk("pre_resume.hold", 32'(bus.count), 32'd2);
        cyc("pre_resume");
        chk("pre_resume.step", 32'(bus.count), 32'd3);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ((i % 20) == 0) begin
                bus.lo = W'($urandom_range(0, 15));
                bus.hi = W'($urandom_range(0, 15));
                if (($urandom_range(0, 7) != 0) && (bus.lo > bus.hi)) begin
                    bus.hi = bus.lo;
                    bus.lo = W'($urandom_range(0, 15)) & bus.hi;
                end
            end
            bus.clr   = ($urandom_range(0, 29) == 0);
            bus.load  = ($urandom_range(0, 9) == 0);
            bus.d     = W'($urandom);
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.up_dn = 1'($urandom);
            bus.mode  = 1'($urandom);
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
